mbox_tx_arb: RTL and testbench
==============================

MBOX_TX_ARB -- requirements
Module: mbox_tx_arb

Interface
REQ-001 SHALL have parameter DW, default 32, width of the link data word.
REQ-002 SHALL have parameter NCH, default 4, number of transmit channels (2..16).
REQ-003 SHALL have parameter DEPTH, default 8, words per channel FIFO (power of two, >=2).
REQ-004 SHALL have derived constant CW = $clog2(NCH), width of the channel tag.
REQ-005 SHALL have a single clock, port aclk, input, 1 bit; all logic is on the rising edge.
REQ-006 SHALL have reset port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port tx_valid, input, NCH bits: per-channel push request.
REQ-008 SHALL have port tx_dat, input, NCH*DW bits: channel i data at [i*DW +: DW].
REQ-009 SHALL have port tx_last, input, NCH bits: the pushed word ends a packet.
REQ-010 SHALL have port tx_ready, output, NCH bits: channel FIFO accepts a word.
REQ-011 SHALL have port ch_abort, input, NCH bits: single-cycle flush request per channel.
REQ-012 SHALL have port mbox_w_dat, output, DW bits: link data.
REQ-013 SHALL have port mbox_w_chan, output, CW bits: channel tag of the current packet.
REQ-014 SHALL have port mbox_w_valid, output, 1 bit: link word valid.
REQ-015 SHALL have port mbox_w_ready, input, 1 bit: link accepts a word.
REQ-016 SHALL have port mbox_w_done, output, 1 bit: the current beat is the packet's last word.
REQ-017 SHALL have port mbox_w_abort, output, 1 bit: one-cycle pulse, in-flight packet abandoned.
REQ-018 SHALL have port irq_sent, output, NCH bits: one-cycle pulse per channel on packet completion.

Function
REQ-019 SHALL give each channel a FIFO of DEPTH entries of {last, data}, push on tx_valid&tx_ready.
REQ-020 SHALL drive tx_ready[i] = !full[i] & !ch_abort[i] & !reset, with no push/pop bypass when full.
REQ-021 SHALL keep a per-channel completed-packet counter: +1 on a push with last, -1 on a link beat with done.
REQ-022 SHALL treat channel i as eligible when its packet counter is nonzero OR its FIFO is full; this lets a packet longer than DEPTH make progress.
REQ-023 SHALL run the FSM states IDLE, SEND and ABORT.
REQ-024 SHALL in IDLE grant round-robin, scanning from last grant+1, and register the grant and tag, entering SEND the next cycle; no eligible channel keeps the FSM in IDLE.
REQ-025 SHALL in SEND assert mbox_w_valid, with mbox_w_dat and mbox_w_done equal to the granted FIFO head and last.
REQ-026 SHALL on a link beat (valid&ready) pop the head, and on a link beat with done pulse irq_sent[grant] in the same cycle and return to IDLE.
REQ-027 SHALL, if the granted FIFO empties mid-packet, drop mbox_w_valid until data arrives while staying in SEND and keeping the grant.
REQ-028 SHALL hold mbox_w_dat, mbox_w_done and mbox_w_chan stable while valid & !ready.
REQ-029 SHALL on ch_abort[i] clear FIFO i pointers and its packet counter on that clock edge, and drop a same-cycle push to i.
REQ-030 SHALL on ch_abort of the granted channel in SEND discard any same-cycle beat, enter ABORT, pulse mbox_w_abort for one cycle, then return to IDLE.
REQ-031 SHALL on ch_abort of a non-granted channel flush that channel only, with no mbox_w_abort.
REQ-032 SHALL have latency from the eligible condition in IDLE to the first mbox_w_valid of exactly 1 cycle.

Reset
REQ-033 SHALL while reset is high clear all FIFOs and counters, set FSM to IDLE and last grant to NCH-1, and drive mbox_w_valid, mbox_w_done, mbox_w_abort, irq_sent, mbox_w_chan and tx_ready to 0.
REQ-034 SHALL treat reset asserted mid-packet as an immediate abandonment, with no mbox_w_abort pulse.

Structure
REQ-035 SHALL place the FSM state enum and the CW derivation function in shared package mbox_pkg.
REQ-036 SHALL instantiate sub-module mbox_fifo (parameters DW+1, DEPTH; ports push, pop, flush, full, empty, count) once per channel in a generate loop.

Verification
REQ-037 Channel 2 pushes 3 words ending in last, ready=1 -> valid, chan=2 for 3 consecutive beats, done on beat 3, irq_sent[2] pulse.
REQ-038 Channels 0 and 3 each hold one 2-word packet, grant starts at 3 -> order 0 then 3, with one IDLE cycle between packets.
REQ-039 DEPTH=8, 12-word packet on channel 1 -> full after 8 words, transmission starts, all 12 words arrive in order.
REQ-040 ch_abort[1] after beat 2 of 5 -> valid drops, mbox_w_abort pulses once, FIFO 1 is empty, next packet from another channel proceeds.
REQ-041 ready held 0 for 4 cycles mid-packet -> data, chan and done stable, no beat lost.
REQ-042 reset asserted during SEND -> all outputs 0 within the same cycle, and a subsequent fresh packet transmits correctly.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and helpers for the mailbox transmit arbiter.
package mbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Channel tag width; a single channel still needs one bit of tag.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Per-channel word FIFO with flush; pointers carry an extra wrap bit.
module mbox_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mbox_tx_arb.sv
// Round-robin packet arbiter: per-channel FIFOs feeding one mailbox link,
// whole packets at a time, with per-channel abort.
module mbox_tx_arb
  import mbox_pkg::*;
#(
  parameter  int unsigned DW    = 32,
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = chan_width(NCH)
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [NCH-1:0]    tx_valid,
  input  logic [NCH*DW-1:0] tx_dat,
  input  logic [NCH-1:0]    tx_last,
  output logic [NCH-1:0]    tx_ready,
  input  logic [NCH-1:0]    ch_abort,
  output logic [DW-1:0]     mbox_w_dat,
  output logic [CW-1:0]     mbox_w_chan,
  output logic              mbox_w_valid,
  input  logic              mbox_w_ready,
  output logic              mbox_w_done,
  output logic              mbox_w_abort,
  output logic [NCH-1:0]    irq_sent
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned FW = DW + 1;

  logic [NCH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]  fifo_dout [NCH];
  logic [AW:0]    fifo_cnt  [NCH];
  logic [PW-1:0]  pkt_cnt_q [NCH];
  logic [PW-1:0]  pkt_cnt_d [NCH];
  logic [NCH-1:0] elig;

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  chan_q, chan_d;
  logic [CW-1:0]  last_q, last_d;
  logic [FW-1:0]  head;
  logic           head_last, beat, found;
  logic [CW-1:0]  pick, cand;
  int unsigned    idx;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mbox_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (aclk),
      .rst   (reset),
      .push  (fifo_push[g]),
      .pop   (fifo_pop[g]),
      .flush (ch_abort[g]),
      .din   ({tx_last[g], tx_dat[g*DW +: DW]}),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .count (fifo_cnt[g])
    );
  end

  assign tx_ready  = ~fifo_full & ~ch_abort & {NCH{~reset}};
  assign fifo_push = tx_valid & tx_ready;

  // Link side decodes straight from registered state and the granted head.
  assign head         = fifo_dout[chan_q];
  assign head_last    = head[DW];
  assign mbox_w_valid = (state_q == ST_SEND) && !fifo_empty[chan_q];
  assign mbox_w_dat   = mbox_w_valid ? head[DW-1:0] : '0;
  assign mbox_w_done  = mbox_w_valid & head_last;
  assign mbox_w_chan  = chan_q;
  assign mbox_w_abort = (state_q == ST_ABORT);
  assign beat         = mbox_w_valid & mbox_w_ready & ~ch_abort[chan_q];

  always_comb begin
    fifo_pop = '0;
    irq_sent = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (beat && (CW'(i) == chan_q)) begin
        fifo_pop[i] = 1'b1;
        irq_sent[i] = head_last;
      end
    end
  end

  // Complete packets queued per channel; a full FIFO also qualifies so
  // packets longer than the FIFO can drain.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
      if (ch_abort[i]) begin
        pkt_cnt_d[i] = '0;
      end else begin
        pkt_cnt_d[i] = pkt_cnt_q[i] + PW'(fifo_push[i] & tx_last[i])
                                    - PW'(irq_sent[i]);
      end
      elig[i] = ((pkt_cnt_q[i] != '0) || (fifo_cnt[i] == (AW+1)'(DEPTH)))
                && !ch_abort[i];
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    last_d  = last_q;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    idx     = 0;
    // Round-robin scan starting just after the previous grant.
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx  = (32'(last_q) + k) % NCH;
      cand = CW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_SEND;
          chan_d  = pick;
          last_d  = pick;
        end
      end
      ST_SEND: begin
        if (ch_abort[chan_q]) begin
          state_d = ST_ABORT;
        end else if (beat && head_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      last_q  <= CW'(NCH - 1);
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mbox_tx_arb.sv
// Directed bench for mbox_tx_arb: packet order, long packets, abort,
// back-pressure and reset mid-packet.
module tb_mbox_tx_arb;

  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 2;

  logic              aclk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    tx_valid;
  logic [NCH*DW-1:0] tx_dat;
  logic [NCH-1:0]    tx_last;
  logic [NCH-1:0]    tx_ready;
  logic [NCH-1:0]    ch_abort;
  logic [DW-1:0]     mbox_w_dat;
  logic [CW-1:0]     mbox_w_chan;
  logic              mbox_w_valid;
  logic              mbox_w_ready;
  logic              mbox_w_done;
  logic              mbox_w_abort;
  logic [NCH-1:0]    irq_sent;

  typedef struct {
    int          cyc;
    int          ch;
    logic        done;
    logic [31:0] dat;
  } beat_t;

  beat_t      beats[$];
  logic [3:0] irqs[$];
  int         n_abort = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_bad = 0;
  bit         stalled;
  int         k;

  always #5 aclk = ~aclk;

  mbox_tx_arb #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_dat       (tx_dat),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .ch_abort     (ch_abort),
    .mbox_w_dat   (mbox_w_dat),
    .mbox_w_chan  (mbox_w_chan),
    .mbox_w_valid (mbox_w_valid),
    .mbox_w_ready (mbox_w_ready),
    .mbox_w_done  (mbox_w_done),
    .mbox_w_abort (mbox_w_abort),
    .irq_sent     (irq_sent)
  );

  always @(posedge aclk) cyc <= cyc + 1;

  // Link-side log, sampled mid-cycle; a beat on an aborting channel is discarded.
  always @(negedge aclk) begin
    if (!reset) begin
      if (mbox_w_valid && mbox_w_ready && !ch_abort[mbox_w_chan])
        beats.push_back('{cyc, int'(mbox_w_chan), mbox_w_done, mbox_w_dat});
      if (irq_sent != '0) irqs.push_back(irq_sent);
      if (mbox_w_abort) n_abort++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Drive one word on every channel in m; channel c carries d ^ (c << 24).
  task automatic push(input logic [3:0] m, input logic [31:0] d, input logic l);
    bit ok;
    ok       = 1'b0;
    tx_valid = m;
    tx_last  = m & {4{l}};
    for (int c = 0; c < NCH; c++) tx_dat[c*DW +: DW] = d ^ (32'(c) << 24);
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      ok = ((tx_ready & m) == m);
      if (!ok) stalled = 1'b1;
      @(posedge aclk);
      #1;
    end
    if (!ok) chk("push_timeout", 64'(tx_ready & m), 64'(m));
    tx_valid = '0;
    tx_last  = '0;
  endtask

  task automatic wait_valid(input string tag);
    for (int t = 0; t < 30 && !mbox_w_valid; t++) tick(1);
    chk(tag, 64'(mbox_w_valid), 64'(1));
  endtask

  task automatic exp_beat(input int i, input int ch, input logic [31:0] d, input logic done);
    if (i < beats.size()) begin
      chk($sformatf("beat%0d_ch", i),   64'(beats[i].ch),   64'(ch));
      chk($sformatf("beat%0d_dat", i),  64'(beats[i].dat),  64'(d ^ (32'(ch) << 24)));
      chk($sformatf("beat%0d_done", i), 64'(beats[i].done), 64'(done));
    end
  endtask

  task automatic clear_logs();
    beats.delete();
    irqs.delete();
    n_abort = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    tx_valid     = '0;
    tx_dat       = '0;
    tx_last      = '0;
    ch_abort     = '0;
    mbox_w_ready = 1'b0;
    stalled      = 1'b0;

    // Outputs while reset is held
    repeat (2) @(negedge aclk);
    chk("rst_valid", 64'(mbox_w_valid), 64'(0));
    chk("rst_done",  64'(mbox_w_done),  64'(0));
    chk("rst_abort", 64'(mbox_w_abort), 64'(0));
    chk("rst_irq",   64'(irq_sent),     64'(0));
    chk("rst_chan",  64'(mbox_w_chan),  64'(0));
    chk("rst_ready", 64'(tx_ready),     64'(0));
    @(posedge aclk);
    #1 reset = 1'b0;
    #1 chk("ready_after_rst", 64'(tx_ready), 64'hF);

    // 3-word packet on channel 2, link always ready
    mbox_w_ready = 1'b1;
    clear_logs();
    push(4'b0100, 32'hA0, 1'b0);
    push(4'b0100, 32'hA1, 1'b0);
    k = cyc;
    push(4'b0100, 32'hA2, 1'b1);
    tick(8);
    chk("t1_nbeats", 64'(beats.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      exp_beat(i, 2, 32'hA0 + 32'(i), i == 2);
      if (i < beats.size()) chk($sformatf("t1_cyc%0d", i), 64'(beats[i].cyc), 64'(k + 2 + i));
    end
    chk("t1_nirq", 64'(irqs.size()), 64'(1));
    if (irqs.size() > 0) chk("t1_irq", 64'(irqs[0]), 64'h4);

    // Channels 0 and 3 loaded together after reset: 0 first, then 3
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    clear_logs();
    push(4'b1001, 32'hB0, 1'b0);
    push(4'b1001, 32'hB1, 1'b1);
    tick(10);
    chk("t2_nbeats", 64'(beats.size()), 64'(4));
    exp_beat(0, 0, 32'hB0, 1'b0);
    exp_beat(1, 0, 32'hB1, 1'b1);
    exp_beat(2, 3, 32'hB0, 1'b0);
    exp_beat(3, 3, 32'hB1, 1'b1);
    if (beats.size() == 4) begin
      chk("t2_gap_in",  64'(beats[1].cyc - beats[0].cyc), 64'(1));
      chk("t2_gap_pkt", 64'(beats[2].cyc - beats[1].cyc), 64'(2));
    end
    chk("t2_nirq", 64'(irqs.size()), 64'(2));
    if (irqs.size() == 2) begin
      chk("t2_irq0", 64'(irqs[0]), 64'h1);
      chk("t2_irq1", 64'(irqs[1]), 64'h8);
    end

    // 12-word packet on channel 1 through an 8-deep FIFO
    clear_logs();
    stalled = 1'b0;
    for (int w = 0; w < 12; w++) push(4'b0010, 32'hC00 + 32'(w), w == 11);
    tick(10);
    chk("t3_full_stall", 64'(stalled), 64'(1));
    chk("t3_nbeats", 64'(beats.size()), 64'(12));
    for (int i = 0; i < 12; i++) exp_beat(i, 1, 32'hC00 + 32'(i), i == 11);
    chk("t3_nirq", 64'(irqs.size()), 64'(1));
    if (irqs.size() > 0) chk("t3_irq", 64'(irqs[0]), 64'h2);

    // Abort channel 1 after 2 of 5 beats; channel 0 then proceeds
    mbox_w_ready = 1'b0;
    clear_logs();
    for (int w = 0; w < 5; w++) push(4'b0010, 32'hD00 + 32'(w), w == 4);
    push(4'b0001, 32'hE00, 1'b0);
    push(4'b0001, 32'hE01, 1'b1);
    tick(2);
    chk("t4_pre_valid", 64'(mbox_w_valid), 64'(1));
    chk("t4_pre_chan",  64'(mbox_w_chan),  64'(1));
    mbox_w_ready = 1'b1;
    tick(2);
    ch_abort = 4'b0010;
    tick(1);
    ch_abort = '0;
    @(negedge aclk);
    chk("t4_valid_drop", 64'(mbox_w_valid), 64'(0));
    chk("t4_abort_puls", 64'(mbox_w_abort), 64'(1));
    tick(12);
    chk("t4_nbeats", 64'(beats.size()), 64'(4));
    exp_beat(0, 1, 32'hD00, 1'b0);
    exp_beat(1, 1, 32'hD01, 1'b0);
    exp_beat(2, 0, 32'hE00, 1'b0);
    exp_beat(3, 0, 32'hE01, 1'b1);
    chk("t4_nabort", 64'(n_abort), 64'(1));
    chk("t4_nirq", 64'(irqs.size()), 64'(1));
    if (irqs.size() > 0) chk("t4_irq", 64'(irqs[0]), 64'h1);

    // Back-pressure for 4 cycles mid-packet on channel 3
    mbox_w_ready = 1'b0;
    clear_logs();
    push(4'b1000, 32'hF00, 1'b0);
    push(4'b1000, 32'hF01, 1'b0);
    push(4'b1000, 32'hF02, 1'b1);
    wait_valid("t5_valid");
    mbox_w_ready = 1'b1;
    tick(1);
    mbox_w_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge aclk);
      chk($sformatf("t5_hold_dat%0d", s),  64'(mbox_w_dat),   64'(32'hF01 ^ 32'h0300_0000));
      chk($sformatf("t5_hold_chan%0d", s), 64'(mbox_w_chan),  64'(3));
      chk($sformatf("t5_hold_done%0d", s), 64'(mbox_w_done),  64'(0));
      chk($sformatf("t5_hold_vld%0d", s),  64'(mbox_w_valid), 64'(1));
    end
    @(posedge aclk);
    #1 mbox_w_ready = 1'b1;
    tick(5);
    chk("t5_nbeats", 64'(beats.size()), 64'(3));
    exp_beat(0, 3, 32'hF00, 1'b0);
    exp_beat(1, 3, 32'hF01, 1'b0);
    exp_beat(2, 3, 32'hF02, 1'b1);
    chk("t5_nirq", 64'(irqs.size()), 64'(1));
    if (irqs.size() > 0) chk("t5_irq", 64'(irqs[0]), 64'h8);

    // Reset during SEND, then a fresh packet
    mbox_w_ready = 1'b0;
    clear_logs();
    push(4'b0100, 32'h900, 1'b0);
    push(4'b0100, 32'h901, 1'b1);
    wait_valid("t6_valid");
    chk("t6_pre_chan", 64'(mbox_w_chan), 64'(2));
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(mbox_w_valid), 64'(0));
    chk("t6_rst_done",  64'(mbox_w_done),  64'(0));
    chk("t6_rst_chan",  64'(mbox_w_chan),  64'(0));
    chk("t6_rst_abort", 64'(mbox_w_abort), 64'(0));
    chk("t6_rst_irq",   64'(irq_sent),     64'(0));
    chk("t6_rst_ready", 64'(tx_ready),     64'(0));
    tick(1);
    reset = 1'b0;
    mbox_w_ready = 1'b1;
    push(4'b0100, 32'h700, 1'b0);
    push(4'b0100, 32'h701, 1'b1);
    tick(8);
    chk("t6_nbeats", 64'(beats.size()), 64'(2));
    exp_beat(0, 2, 32'h700, 1'b0);
    exp_beat(1, 2, 32'h701, 1'b1);
    chk("t6_nabort", 64'(n_abort), 64'(0));
    chk("t6_nirq", 64'(irqs.size()), 64'(1));
    if (irqs.size() > 0) chk("t6_irq", 64'(irqs[0]), 64'h4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
